// File: rtl/uart_pkg.sv
// Purpose: shared constants, FSM encoding and helpers for the UART receive controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   // Worst-case frame: start + 8 data + parity + stop.
   localparam int FRAME_BITS = 11;

   // Quiet counter width; holds up to 511, above the 352-cycle worst case.
   localparam int QUIET_W = 9;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_APPLY = 1'b1
   } state_t;

   function automatic logic prescale_legal(input logic [5:0] ps);
      return (ps == PRESCALE_8) || (ps == PRESCALE_16) || (ps == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Purpose: small synchronous byte FIFO with level and sticky overflow.
// Latency: a push is visible at the head one cycle later (registered head, no fall-through).
// Backpressure: pop only when not empty; a push into a full FIFO without a pop is dropped and flags ovf.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop_req,
   input  logic          ovf_clr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          full,
   output logic [LW-1:0] level,
   output logic          ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          empty;
   logic          pop;
   logic          push_ok;
   logic          drop;

   assign empty    = (level == '0);
   assign full     = (level == LW'(DEPTH));
   assign pop      = pop_req & ~empty;
   // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
   assign push_ok  = push & (~full | pop);
   assign drop     = push & full & ~pop;
   assign rd_valid = ~empty;
   assign rd_data  = mem[rd_ptr];

   // Storage, pointers (natural power-of-two wrap), occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      level <= level + 1'b1;
         else if (pop && !push_ok) level <= level - 1'b1;
         // A fresh overflow outranks a coincident clear.
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Purpose: holds UART_RX settings, applies new ones only after a full idle frame, buffers received bytes.
// Latency: config applies 1 cycle after idle is reached, receiver held in reset 2 cycles; bytes readable 1 cycle after data_valid.
// Backpressure: ready/valid read port; bytes arriving into a full FIFO without a pop are dropped and flag ovf.
module uart_rx_ctrl #(
   parameter int DEPTH      = 4,
   parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       RX_IN,
   input  logic                       cfg_wr,
   input  logic [5:0]                 cfg_prescale,
   input  logic                       cfg_par_en,
   input  logic                       cfg_par_typ,
   output logic                       cfg_busy,
   output logic                       cfg_err,
   output logic [5:0]                 prescale,
   output logic                       PAR_EN,
   output logic                       PAR_TYP,
   output logic                       rx_rst_n,
   input  logic [7:0]                 P_DATA,
   input  logic                       data_valid,
   output logic [7:0]                 rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       ovf,
   input  logic                       ovf_clr
);

   import uart_pkg::*;

   state_t             state_q;
   state_t             state_d;
   logic               phase_q;
   logic               go_apply;
   logic               pend_q;
   logic [5:0]         pend_ps;
   logic               pend_en;
   logic               pend_typ;
   logic [QUIET_W-1:0] quiet_q;
   logic [15:0]        idle_thr;
   logic               idle;
   logic               wr_legal;
   logic               cfg_err_q;
   logic               fifo_full;

   assign wr_legal = cfg_wr & prescale_legal(cfg_prescale);
   // Idle threshold tracks the prescale currently in force (88/176/352 cycles).
   assign idle_thr = 16'(FRAME_BITS) * {10'd0, prescale};
   assign idle     = {{(16-QUIET_W){1'b0}}, quiet_q} >= idle_thr;

   assign cfg_busy = pend_q | (state_q == S_APPLY);
   assign cfg_err  = cfg_err_q;
   assign rx_rst_n = ~RST & (state_q != S_APPLY);

   // Next-state logic: leave RUN when a pending config meets an idle line; APPLY lasts two cycles.
   always_comb begin
      state_d  = state_q;
      go_apply = 1'b0;
      case (state_q)
         S_RUN: begin
            if (pend_q && idle) begin
               state_d  = S_APPLY;
               go_apply = 1'b1;
            end
         end
         S_APPLY: begin
            if (phase_q) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   // State register plus the second-cycle marker for APPLY.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_RUN;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= (state_q == S_APPLY) && !phase_q;
      end
   end

   // Pending/active configuration; a write landing on the apply edge stays pending for the next round.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_q    <= 1'b0;
         pend_ps   <= PRESCALE_8;
         pend_en   <= 1'b0;
         pend_typ  <= 1'b0;
         prescale  <= PRESCALE_8;
         PAR_EN    <= 1'b0;
         PAR_TYP   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_wr & ~wr_legal;
         if (go_apply) begin
            prescale <= pend_ps;
            PAR_EN   <= pend_en;
            PAR_TYP  <= pend_typ;
         end
         if (wr_legal) begin
            pend_q   <= 1'b1;
            pend_ps  <= cfg_prescale;
            pend_en  <= cfg_par_en;
            pend_typ <= cfg_par_typ;
         end else if (go_apply) begin
            pend_q <= 1'b0;
         end
      end
   end

   // Saturating count of consecutive high line cycles; restarts on any low bit or an apply.
   always_ff @(posedge CLK) begin
      if (RST || go_apply || !RX_IN) begin
         quiet_q <= '0;
      end else if (quiet_q != '1) begin
         quiet_q <= quiet_q + 1'b1;
      end
   end

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .DW    (8)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (data_valid),
      .push_data (P_DATA),
      .pop_req   (rd_ready),
      .ovf_clr   (ovf_clr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .full      (fifo_full),
      .level     (level),
      .ovf       (ovf)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose: self-checking bench for uart_rx_ctrl against a behavioural model, directed and random stimulus.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: random rd_ready drives FIFO full/empty and overflow corners.
module tb_uart_rx_ctrl;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic       cfg_wr;
   logic [5:0] cfg_prescale;
   logic       cfg_par_en;
   logic       cfg_par_typ;
   logic       cfg_busy;
   logic       cfg_err;
   logic [5:0] prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       rx_rst_n;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [2:0] level;
   logic       ovf;
   logic       ovf_clr;

   int checks   = 0;
   int failures = 0;

   uart_rx_ctrl #(.DEPTH(4), .FRAME_BITS(11)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
      .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err), .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .rx_rst_n(rx_rst_n), .P_DATA(P_DATA), .data_valid(data_valid),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural model: the state as visible during the current cycle.
   byte unsigned m_q[$];
   bit  m_ovf;
   int  m_quiet;
   int  m_apply_left;
   bit  m_pend;
   int  m_pend_ps;
   bit  m_pend_en, m_pend_typ;
   int  m_ps;
   bit  m_en, m_typ;
   bit  m_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 0; m_quiet = 0; m_apply_left = 0;
      m_pend = 0; m_pend_ps = 8; m_pend_en = 0; m_pend_typ = 0;
      m_ps = 8; m_en = 0; m_typ = 0; m_err = 0;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_update();
      bit legal, idle, go, pop;
      int sz;
      if (RST) begin
         model_reset();
         return;
      end
      legal = (cfg_prescale == 8) || (cfg_prescale == 16) || (cfg_prescale == 32);
      idle  = (m_quiet >= 11 * m_ps);
      go    = (m_apply_left == 0) && m_pend && idle;
      m_err = cfg_wr && !legal;
      if (go) begin
         m_ps = m_pend_ps; m_en = m_pend_en; m_typ = m_pend_typ;
      end
      if (cfg_wr && legal) begin
         m_pend = 1; m_pend_ps = int'(cfg_prescale); m_pend_en = cfg_par_en; m_pend_typ = cfg_par_typ;
      end else if (go) begin
         m_pend = 0;
      end
      if (go)                m_apply_left = 2;
      else if (m_apply_left > 0) m_apply_left--;
      if (go || !RX_IN)      m_quiet = 0;
      else if (m_quiet < 511) m_quiet++;
      sz  = m_q.size();
      pop = rd_ready && (sz > 0);
      if (pop) void'(m_q.pop_front());
      if (data_valid) begin
         if (sz < 4 || pop) m_q.push_back(P_DATA);
         else               m_ovf = 1;
      end
      if (!(data_valid && sz == 4 && !pop) && ovf_clr) m_ovf = 0;
   endtask

   task automatic compare();
      chk("prescale", int'(prescale), m_ps);
      chk("par_en", int'(PAR_EN), int'(m_en));
      chk("par_typ", int'(PAR_TYP), int'(m_typ));
      chk("cfg_busy", int'(cfg_busy), int'(m_pend || (m_apply_left > 0)));
      chk("cfg_err", int'(cfg_err), int'(m_err));
      chk("rx_rst_n", int'(rx_rst_n), int'(!RST && (m_apply_left == 0)));
      chk("rd_valid", int'(rd_valid), int'(m_q.size() > 0));
      chk("level", int'(level), m_q.size());
      chk("ovf", int'(ovf), int'(m_ovf));
      if (m_q.size() > 0) chk("rd_data", int'(rd_data), int'(m_q[0]));
   endtask

   task automatic step();
      @(posedge CLK);
      model_update();
      @(negedge CLK);
      compare();
   endtask

   task automatic quiet_inputs();
      RX_IN = 1; cfg_wr = 0; cfg_prescale = 6'd8; cfg_par_en = 0; cfg_par_typ = 0;
      P_DATA = 8'h00; data_valid = 0; rd_ready = 0; ovf_clr = 0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      RST = 1;
      step();
      step();
      RST = 0;
   endtask

   int n;
   int lows;
   int ps_tab[8] = '{8, 16, 32, 12, 0, 63, 16, 8};

   initial begin
      RST = 1;
      quiet_inputs();
      model_reset();
      @(negedge CLK);
      do_reset();

      // Reset values, observed while RST is still asserted.
      RST = 1;
      step();
      chk("rst_rx_rst_n", int'(rx_rst_n), 0);
      RST = 0;
      chk("rst_prescale", int'(prescale), 8);
      chk("rst_level", int'(level), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_busy", int'(cfg_busy), 0);

      // Single byte through the FIFO.
      P_DATA = 8'hAB; data_valid = 1;
      step();
      data_valid = 0;
      chk("t1_rd_valid", int'(rd_valid), 1);
      chk("t1_rd_data", int'(rd_data), 8'hAB);
      chk("t1_level", int'(level), 1);
      rd_ready = 1;
      step();
      rd_ready = 0;
      chk("t1_level_pop", int'(level), 0);

      // Legal config with the line idle: applies once 88 quiet cycles are seen.
      do_reset();
      cfg_wr = 1; cfg_prescale = 6'd16; cfg_par_en = 1; cfg_par_typ = 1;
      step();
      cfg_wr = 0;
      chk("t2_busy", int'(cfg_busy), 1);
      n = 0;
      while (rx_rst_n && n < 400) begin step(); n++; end
      chk("t2_apply_delay", n, 88);
      chk("t2_prescale", int'(prescale), 16);
      lows = 0;
      while (!rx_rst_n && lows < 10) begin lows++; step(); end
      chk("t2_rst_low_cycles", lows, 2);
      chk("t2_busy_fall", int'(cfg_busy), 0);
      chk("t2_par_en", int'(PAR_EN), 1);
      chk("t2_par_typ", int'(PAR_TYP), 1);

      // A low bit on the line restarts the idle wait.
      do_reset();
      cfg_wr = 1; cfg_prescale = 6'd16;
      step();
      cfg_wr = 0;
      n = 0;
      while (rx_rst_n && n < 400) begin
         RX_IN = (n + 2 == 50) ? 1'b0 : 1'b1;
         step();
         n++;
      end
      RX_IN = 1;
      chk("t3_apply_delay", n, 138);
      step(); step();

      // Illegal prescale: error pulse only.
      cfg_wr = 1; cfg_prescale = 6'd12; cfg_par_en = 1;
      step();
      cfg_wr = 0;
      chk("t4_err", int'(cfg_err), 1);
      chk("t4_busy", int'(cfg_busy), 0);
      chk("t4_prescale", int'(prescale), 16);
      step();
      chk("t4_err_clear", int'(cfg_err), 0);

      // Overflow: fifth byte dropped, first four read back in order.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         P_DATA = 8'(i); data_valid = 1;
         step();
      end
      data_valid = 0;
      chk("t5_level", int'(level), 4);
      chk("t5_ovf", int'(ovf), 1);
      for (int i = 1; i <= 4; i++) begin
         chk("t5_rd_data", int'(rd_data), i);
         rd_ready = 1;
         step();
         rd_ready = 0;
      end
      chk("t5_empty", int'(rd_valid), 0);
      ovf_clr = 1;
      step();
      ovf_clr = 0;
      chk("t5_ovf_clr", int'(ovf), 0);

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < 4; i++) begin
         P_DATA = 8'h10 + 8'(i); data_valid = 1;
         step();
      end
      P_DATA = 8'h99; data_valid = 1; rd_ready = 1;
      step();
      data_valid = 0;
      chk("t6_level", int'(level), 4);
      chk("t6_ovf", int'(ovf), 0);
      chk("t6_head", int'(rd_data), 8'h11);
      step(); step(); step();
      chk("t6_last", int'(rd_data), 8'h99);
      step();
      rd_ready = 0;
      chk("t6_drained", int'(level), 0);

      // Randomised traffic checked cycle by cycle against the model.
      for (int c = 0; c < 6000; c++) begin
         RST          = ($urandom_range(0, 1499) == 0);
         RX_IN        = ($urandom_range(0, 299) != 0);
         cfg_wr       = ($urandom_range(0, 149) == 0);
         cfg_prescale = 6'(ps_tab[$urandom_range(0, 7)]);
         cfg_par_en   = 1'($urandom_range(0, 1));
         cfg_par_typ  = 1'($urandom_range(0, 1));
         P_DATA       = 8'($urandom_range(0, 255));
         data_valid   = ($urandom_range(0, 99) < 40);
         rd_ready     = ($urandom_range(0, 99) < 40);
         ovf_clr      = ($urandom_range(0, 99) < 5);
         step();
      end
      RST = 0;
      quiet_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Configuration and buffering controller for `UART_RX`. It holds the receiver's `prescale`/`PAR_EN`/`PAR_TYP` settings and applies new settings only when the serial line has been idle for a full worst-case frame, resetting the receiver around each change. Bytes from `P_DATA`/`data_valid` go into a 4-entry FIFO with a ready/valid read port. The block sits between `UART_RX` and the host or register logic.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two.
- `FRAME_BITS`, 11: worst-case frame length in bits (start + 8 data + parity + stop) used for idle detection.

Ports:
- `CLK` in 1: single clock, same clock as `UART_RX`.
- `RST` in 1: synchronous, active-high reset.
- `RX_IN` in 1: serial line, monitored for idle only.
- `cfg_wr` in 1: single-cycle configuration write strobe.
- `cfg_prescale` in 6: requested prescale; legal values are 8, 16 and 32.
- `cfg_par_en` in 1: requested parity enable.
- `cfg_par_typ` in 1: requested parity type (0 even, 1 odd).
- `cfg_busy` out 1: a configuration is pending or being applied.
- `cfg_err` out 1: one-cycle pulse when `cfg_wr` carries an illegal prescale.
- `prescale` out 6: active prescale, to `UART_RX`.
- `PAR_EN` out 1: active parity enable, to `UART_RX`.
- `PAR_TYP` out 1: active parity type, to `UART_RX`.
- `rx_rst_n` out 1: active-low reset, to `UART_RX.RST`.
- `P_DATA` in 8: received byte from `UART_RX`.
- `data_valid` in 1: received-byte strobe from `UART_RX`.
- `rd_data` out 8: FIFO head byte.
- `rd_valid` out 1: FIFO is not empty.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `level` out 3: FIFO occupancy, 0 to `DEPTH`.
- `ovf` out 1: sticky overflow flag.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Reset values:
  - `prescale`=8, `PAR_EN`=0, `PAR_TYP`=0.
  - `rx_rst_n`=0 while `RST` is high.
  - `cfg_busy`=0, `cfg_err`=0, `rd_valid`=0, `level`=0, `ovf`=0, `rd_data`=0.
  - FSM in `S_RUN`; pending register cleared; quiet counter cleared.
- Config write:
  - `cfg_wr` with a legal prescale loads the pending register and sets the pending flag.
  - A later legal write overwrites the pending value (last writer wins).
  - An illegal prescale raises `cfg_err` for one cycle, leaves pending state untouched, and does not raise `cfg_busy`.
- Quiet counter:
  - 9 bits, saturating.
  - Increments each cycle `RX_IN`=1; cleared on any `RX_IN`=0.
  - Idle when count >= `FRAME_BITS` × active `prescale` (88 / 176 / 352 cycles).
- FSM:
  - `S_RUN`: if pending and idle, go to `S_APPLY`.
  - `S_APPLY`, entry cycle: active registers load from pending, pending clears, quiet counter clears, `rx_rst_n`=0.
  - `S_APPLY` lasts 2 cycles with `rx_rst_n`=0, then returns to `S_RUN` with `rx_rst_n`=1.
  - A `cfg_wr` arriving during `S_APPLY` sets pending again. That config is applied after a fresh idle period.
- `cfg_busy` = pending OR state==`S_APPLY`.
- FIFO:
  - Push on `data_valid`; pop on `rd_valid` & `rd_ready`.
  - Push and pop in the same cycle: both take effect and `level` is unchanged. This holds even when full.
  - Push when full with no pop: the byte is dropped and `ovf` is set.
  - Pop when empty is ignored.
  - Pointers wrap modulo `DEPTH`.
  - `ovf_clr` clears `ovf`. If `ovf_clr` coincides with a new overflow, the set wins.
  - FIFO contents are not touched by `S_APPLY`.

## Timing
- `data_valid` at cycle N: `rd_valid`=1 and `rd_data` valid from cycle N+1 when the FIFO was empty (registered head, no fall-through).
- `cfg_wr` at cycle N: `cfg_busy`=1 from N+1; `cfg_err` at N+1 if illegal.
- Idle first satisfied at cycle M with pending: `S_APPLY` at M+1, new `prescale` visible at M+1, `rx_rst_n` low at M+1 and M+2, high at M+3, `cfg_busy` low at M+3.
- `RST` mid-apply: returns to reset values at the next edge; pending config is lost.

## Structure
- Shared package `uart_pkg`:
  - prescale legal-value constants (8/16/32);
  - `FRAME_BITS`;
  - FSM state encoding (`S_RUN`, `S_APPLY`).
- One sub-module: `uart_rx_fifo`, a synchronous FIFO with push/pop, level, full/empty and overflow.
- Controller FSM and quiet counter stay in the top.

## Test plan
- Reset, then `P_DATA`=0xAB with `data_valid` -> `rd_valid`=1 next cycle, `rd_data`=0xAB, `level`=1; pop -> `level`=0.
- `cfg_wr` prescale=16, par_en=1, typ=1 with `RX_IN`=1 held -> apply after 88 idle cycles; `prescale`=16; `rx_rst_n` low exactly 2 cycles; `cfg_busy` falls.
- `cfg_wr` prescale=16, then pulse `RX_IN`=0 at cycle 50 -> apply is delayed until 88 cycles after `RX_IN` returns high.
- `cfg_wr` prescale=12 -> `cfg_err` for one cycle, `cfg_busy`=0, outputs unchanged.
- Push 5 bytes 0x01–0x05 with `rd_ready`=0 -> `level`=4, `ovf`=1, reads return 0x01–0x04; `ovf_clr` clears `ovf`.
- FIFO full, `data_valid` together with `rd_ready` -> `level` stays 4, `ovf`=0, new byte appears last.
